// File: rtl/load_store_unit.sv
// RV32I load/store unit: checks, aligns and issues one request at a time to a
// word-addressed memory with one-cycle read latency; formats load data.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvld
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HI_LSB = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;

    logic              req_err_c;
    logic [3:0]        wen_c;
    logic [WORD_W-1:0] wdata_w_c;
    logic [WORD_W-1:0] wdata_rep_c;
    logic [WORD_W-1:0] rdata_w_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [WORD_W-1:0] ld_fmt_c;

    // Request checks: illegal funct3, misalignment, address beyond memory
    always_comb begin
        req_err_c = 1'b0;
        if (req_we) begin
            if (req_funct3[2] || (req_funct3[1:0] == 2'd3)) req_err_c = 1'b1;
        end else begin
            if ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11)) req_err_c = 1'b1;
        end
        if ((req_funct3[1:0] == 2'd1) && req_addr[0]) req_err_c = 1'b1;
        if ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0)) req_err_c = 1'b1;
        if ((req_addr >> HI_LSB) != 32'd0) req_err_c = 1'b1;
    end

    // Store strobes and lane-replicated write data
    always_comb begin
        wdata_w_c = WORD_W'(req_wdata);
        case (req_funct3[1:0])
            2'd0: begin
                wen_c       = 4'b0001 << req_addr[1:0];
                wdata_rep_c = {4{wdata_w_c[7:0]}};
            end
            2'd1: begin
                wen_c       = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep_c = {2{wdata_w_c[15:0]}};
            end
            default: begin
                wen_c       = 4'b1111;
                wdata_rep_c = wdata_w_c;
            end
        endcase
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        rdata_w_c = WORD_W'(mem_rdata);
        byte_c    = rdata_w_c[{lane_q, 3'b000} +: 8];
        half_c    = lane_q[1] ? rdata_w_c[31:16] : rdata_w_c[15:0];
        case (funct3_q)
            3'd0:    ld_fmt_c = {{24{byte_c[7]}}, byte_c};
            3'd1:    ld_fmt_c = {{16{half_c[15]}}, half_c};
            3'd4:    ld_fmt_c = {24'd0, byte_c};
            3'd5:    ld_fmt_c = {16'd0, half_c};
            default: ld_fmt_c = rdata_w_c;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 4'd0;
            we_q      <= 1'b0;
            funct3_q  <= 3'd0;
            lane_q    <= 2'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_wen   <= 4'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        lane_q    <= req_addr[1:0];
                        if (req_err_c) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end else begin
                            mem_en    <= 1'b1;
                            mem_addr  <= req_addr[ADDR_WIDTH+1:2];
                            mem_wen   <= req_we ? wen_c : 4'd0;
                            mem_wdata <= req_we ? DATA_WIDTH'(wdata_rep_c) : '0;
                            rsp_valid <= req_we;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvld) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= DATA_WIDTH'(ld_fmt_c);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
